// File: rtl/rx_work_ram.sv
// rtl/rx_work_ram.sv - double-buffered receive work RAM between the MCU-bridge writer and the CPU reader
module rx_work_ram #(
    parameter int RAMSIZE = 32
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_W2_WR,
    input  logic [6:0] i_W2_WR_INDEX,
    input  logic [7:0] i_W2_WR_DATA,
    input  logic       i_W2_COMMIT,
    output logic [7:0] o_W2_DROP_CNT,
    input  logic       i_R1_RD,
    input  logic       i_R1_REWIND,
    output logic [7:0] o_R1_RD_DATA,
    output logic       o_R1_READY
);

    // Address width of one bank; at least one bit so RAMSIZE = 1 still builds.
    localparam int         AW      = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [6:0] LP_SIZE = 7'(RAMSIZE);
    localparam logic [6:0] LP_LAST = 7'(RAMSIZE - 1);

    // Two banks; slots at or beyond RAMSIZE are never written or read.
    logic [7:0] r_ram [0:1][0:DEPTH-1];

    logic       r_bank_w;
    logic       r_bank_r;
    logic [2:0] r_rd_sft;
    logic [2:0] r_rw_sft;
    logic [6:0] r_rd_ptr;
    logic [7:0] r_rd_data;
    logic       r_have_frame;
    logic       r_pend;
    logic       r_swap_req;
    logic [7:0] r_drop_cnt;

    logic w_wr_en;
    logic w_rd_trail;
    logic w_rw_lead;
    logic w_req_now;
    logic w_swap;

    // Out-of-range indices must not alias into the bank through the sliced address.
    assign w_wr_en    = i_W2_WR && (i_W2_WR_INDEX < LP_SIZE);
    assign w_rd_trail = (r_rd_sft == 3'b100);
    assign w_rw_lead  = (r_rw_sft == 3'b011);
    // A commit arriving in the rewind cycle counts as something to publish.
    assign w_req_now  = w_rw_lead && (r_pend || i_W2_COMMIT);
    // The swap waits for a gap in the write stream so a byte never straddles banks.
    assign w_swap     = (w_req_now || r_swap_req) && !i_W2_WR;

    // Byte write into the current write bank; storage is deliberately not reset.
    always_ff @(posedge i_CLK) begin
        if (w_wr_en) begin
            r_ram[r_bank_w][i_W2_WR_INDEX[AW-1:0]] <= i_W2_WR_DATA;
        end
    end

    // Three-stage synchronisers for the asynchronous CPU strobes.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_rd_sft <= 3'b000;
            r_rw_sft <= 3'b000;
        end else begin
            r_rd_sft <= {r_rd_sft[1:0], i_R1_RD};
            r_rw_sft <= {r_rw_sft[1:0], i_R1_REWIND};
        end
    end

    // Read pointer: rewind has priority over a coincident read trailing edge.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_rd_ptr <= 7'd0;
        end else if (w_rw_lead) begin
            r_rd_ptr <= 7'd0;
        end else if (w_rd_trail) begin
            r_rd_ptr <= (r_rd_ptr == LP_LAST) ? 7'd0 : r_rd_ptr + 7'd1;
        end
    end

    // Bank ownership and publication state; banks only trade places on a swap.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_bank_w     <= 1'b0;
            r_bank_r     <= 1'b1;
            r_have_frame <= 1'b0;
            r_swap_req   <= 1'b0;
        end else if (w_swap) begin
            r_bank_w     <= ~r_bank_w;
            r_bank_r     <= ~r_bank_r;
            r_have_frame <= 1'b1;
            r_swap_req   <= 1'b0;
        end else if (w_req_now) begin
            r_swap_req   <= 1'b1;
        end
    end

    // Pending flag: a commit landing in the swap cycle is published by that swap.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_pend <= 1'b0;
        end else if (w_swap) begin
            r_pend <= 1'b0;
        end else if (i_W2_COMMIT) begin
            r_pend <= 1'b1;
        end
    end

    // Saturating count of committed frames overwritten before the CPU fetched them.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_drop_cnt <= 8'd0;
        end else if (i_W2_COMMIT && r_pend && !r_swap_req && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Registered read data; zero until a frame has ever been published.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_rd_data <= 8'h00;
        end else if (r_have_frame) begin
            r_rd_data <= r_ram[r_bank_r][r_rd_ptr[AW-1:0]];
        end else begin
            r_rd_data <= 8'h00;
        end
    end

    assign o_R1_RD_DATA  = r_rd_data;
    assign o_R1_READY    = r_pend;
    assign o_W2_DROP_CNT = r_drop_cnt;

endmodule
